// File: rtl/tappy_pkg.sv
// Shared definitions for the tappy clock/data link, used by both the transmitter and the receiver.
// Frame on the wire: start bit, 8 data bits LSB first, odd parity bit, stop bit.
package tappy_pkg;

    localparam int FRAME_BITS = 11;
    localparam int START      = 0;
    localparam int DATA0      = 1;
    localparam int PARITY     = 9;
    localparam int STOP       = 10;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
        logic [FRAME_BITS-1:0] f;
        f              = '0;
        f[START]       = 1'b0;
        f[DATA0 +: 8]  = b;
        f[PARITY]      = odd_parity(b);
        f[STOP]        = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/tappy_clkgen.sv
// Link clock generator: half-period counter that toggles the clk level and pulses tick every HALF_PERIOD enabled cycles.
// Restart (on accept) forces the level high and the counter to zero so every frame starts on a full high half.
module tappy_clkgen #(
    parameter int HALF_PERIOD = 4
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick,
    output logic level
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (restart) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (tick) begin
            cnt   <= '0;
            level <= ~level;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tappy_tx.sv
// Tappy link transmitter: one byte per valid/ready accept, sent as an 11-bit frame on clk/dat, start bit visible the cycle after accept.
// ready stays low for 22*HALF_PERIOD + IDLE_GAP*2*HALF_PERIOD cycles; valid while ready is low is ignored.
module tappy_tx
    import tappy_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int IDLE_GAP    = 2
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [7:0] word,
    input  logic       valid,
    output logic       ready,
    output logic       clk,
    output logic       dat,
    output logic       busy
);

    localparam int GAP_CYC = IDLE_GAP * 2 * HALF_PERIOD;
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [3:0]    LAST_BIT = 4'(STOP);

    generate
        if (HALF_PERIOD < 2) begin : g_bad_half_period
            $error("tappy_tx: HALF_PERIOD must be at least 2");
        end
        if (IDLE_GAP < 0) begin : g_bad_idle_gap
            $error("tappy_tx: IDLE_GAP must not be negative");
        end
    endgenerate

    state_t                state;
    logic [FRAME_BITS-1:0] frame;
    logic [3:0]            idx;
    logic [GW-1:0]         gap_cnt;
    logic                  accept;
    logic                  tick;
    logic                  bit_end;

    assign accept  = (state == IDLE) && valid && ready;
    // A bit ends when the low half expires; the clkgen raises clk on that same edge.
    assign bit_end = tick && !clk;

    tappy_clkgen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clkgen (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .en     (state == SHIFT),
        .restart(accept),
        .tick   (tick),
        .level  (clk)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            frame   <= '1;
            idx     <= '0;
            gap_cnt <= '0;
            dat     <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame <= make_frame(word);
                        idx   <= '0;
                        dat   <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        if (idx == LAST_BIT) begin
                            dat     <= 1'b1;
                            gap_cnt <= '0;
                            if (GAP_CYC == 0) begin
                                ready <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                            dat <= frame[idx + 4'd1];
                        end
                    end
                end
                GAP: begin
                    // Release ready one cycle early so a held valid is taken on the first IDLE cycle.
                    if (gap_cnt == GAP_LAST) begin
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    dat   <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tappy_tx.sv
// Directed bench for tappy_tx: instance a (HALF_PERIOD=4, IDLE_GAP=2) and b (2, 0), each watched by a
// behavioural receiver that samples dat on every falling link clk and measures the idle gap after each stop bit.
module tb_tappy_tx;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [7:0] word_a, word_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b, clk_a, clk_b, dat_a, dat_b, busy_a, busy_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 sysclk = ~sysclk;

    tappy_tx #(.HALF_PERIOD(4), .IDLE_GAP(2)) dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .word(word_a), .valid(valid_a),
        .ready(ready_a), .clk(clk_a), .dat(dat_a), .busy(busy_a)
    );

    tappy_tx #(.HALF_PERIOD(2), .IDLE_GAP(0)) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .word(word_b), .valid(valid_b),
        .ready(ready_b), .clk(clk_b), .dat(dat_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver models: shift in 11 bits per frame, then count clk=1/dat=1 cycles while busy after the stop bit.
    int         a_n = 0, a_done = 0, a_fmt_bad = 0, a_gap_bad = 0, a_gaps = 0, a_gcnt = 0;
    logic       a_pclk = 1'b1, a_after = 1'b0;
    logic [10:0] a_sh = '0, a_last = '0;
    logic [7:0] a_rxq[$];

    int         b_n = 0, b_done = 0, b_fmt_bad = 0, b_gap_bad = 0, b_gaps = 0, b_gcnt = 0;
    logic       b_pclk = 1'b1, b_after = 1'b0;
    logic [10:0] b_sh = '0;
    logic [7:0] b_rxq[$];

    always @(negedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            a_n = 0; a_pclk = 1'b1; a_after = 1'b0; a_gcnt = 0;
        end else begin
            if (a_pclk && !clk_a) begin
                a_sh[a_n] = dat_a;
                a_n++;
                if (a_n == 11) begin
                    a_n = 0; a_last = a_sh; a_done++;
                    a_rxq.push_back(a_sh[8:1]);
                    if (a_sh[0] != 1'b0 || a_sh[10] != 1'b1 || a_sh[9] != ~^a_sh[8:1]) a_fmt_bad++;
                    a_after = 1'b1; a_gcnt = 0;
                end
            end
            if (a_after) begin
                if (!busy_a) begin
                    a_after = 1'b0; a_gaps++;
                    if (a_gcnt != 16) a_gap_bad++;
                end else if (clk_a && dat_a) begin
                    a_gcnt++;
                end
            end
            a_pclk = clk_a;
        end
    end

    always @(negedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            b_n = 0; b_pclk = 1'b1; b_after = 1'b0; b_gcnt = 0;
        end else begin
            if (b_pclk && !clk_b) begin
                b_sh[b_n] = dat_b;
                b_n++;
                if (b_n == 11) begin
                    b_n = 0; b_done++;
                    b_rxq.push_back(b_sh[8:1]);
                    if (b_sh[0] != 1'b0 || b_sh[10] != 1'b1 || b_sh[9] != ~^b_sh[8:1]) b_fmt_bad++;
                    b_after = 1'b1; b_gcnt = 0;
                end
            end
            if (b_after) begin
                if (!busy_b) begin
                    b_after = 1'b0; b_gaps++;
                    if (b_gcnt != 0) b_gap_bad++;
                end else if (clk_b && dat_b) begin
                    b_gcnt++;
                end
            end
            b_pclk = clk_b;
        end
    end

    // Returns at the falling sysclk edge of the first cycle after the accept edge, with valid dropped.
    task automatic send_a(input logic [7:0] b);
        int t = 0;
        @(negedge sysclk);
        word_a = b; valid_a = 1'b1;
        while (!ready_a && t < 1000) begin @(negedge sysclk); t++; end
        check("send_a_ready", t < 1000, 1);
        @(negedge sysclk);
        valid_a = 1'b0;
    endtask

    task automatic wait_idle_a();
        int t = 0;
        while ((busy_a || !ready_a) && t < 2000) begin @(negedge sysclk); t++; end
        check("idle_a_timeout", t < 2000, 1);
        repeat (2) @(negedge sysclk);
    endtask

    task automatic wait_idle_b();
        int t = 0;
        while ((busy_b || !ready_b) && t < 2000) begin @(negedge sysclk); t++; end
        check("idle_b_timeout", t < 2000, 1);
        repeat (2) @(negedge sysclk);
    endtask

    task automatic expect_rx_a(input string tag, input logic [7:0] exp);
        check({tag, "_count"}, a_rxq.size(), 1);
        if (a_rxq.size() > 0) check(tag, a_rxq.pop_front(), exp);
    endtask

    task automatic loop_a(output int to);
        int t;
        to = 0;
        @(negedge sysclk);
        valid_a = 1'b1;
        for (int b = 0; b < 256; b++) begin
            word_a = 8'(b);
            t = 0;
            while (!ready_a && t < 1000) begin @(negedge sysclk); t++; end
            if (t >= 1000) to++;
            @(posedge sysclk);
            #1;
        end
        valid_a = 1'b0;
    endtask

    task automatic loop_b(output int to);
        int t;
        to = 0;
        @(negedge sysclk);
        valid_b = 1'b1;
        for (int b = 0; b < 256; b++) begin
            word_b = 8'(b);
            t = 0;
            while (!ready_b && t < 1000) begin @(negedge sysclk); t++; end
            if (t >= 1000) to++;
            @(posedge sysclk);
            #1;
        end
        valid_b = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still going at 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, base, base_b, gbase, gbase_b, to_a, to_b;
        rst_n = 1'b0;
        word_a = '0; valid_a = 1'b0; word_b = '0; valid_b = 1'b0;
        repeat (2) @(negedge sysclk);
        check("rst_clk_a", clk_a, 1);
        check("rst_dat_a", dat_a, 1);
        check("rst_ready_a", ready_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_clk_b", clk_b, 1);
        check("rst_ready_b", ready_b, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);

        // 0xA5: latency, bit pattern, ready-low window
        send_a(8'hA5);
        check("a5_start_dat", dat_a, 0);
        check("a5_busy", busy_a, 1);
        check("a5_ready", ready_a, 0);
        c = 1;
        while (clk_a && c < 50) begin @(negedge sysclk); c++; end
        check("a5_first_fall", c, 5);
        while (!ready_a && c < 500) begin @(negedge sysclk); c++; end
        check("a5_ready_low", c - 1, 104);
        check("a5_frame", a_last, 11'b1_1_10100101_0);
        expect_rx_a("a5_word", 8'hA5);
        wait_idle_a();

        send_a(8'h00);
        wait_idle_a();
        check("x00_frame", a_last, 11'b1_1_00000000_0);
        expect_rx_a("x00_word", 8'h00);

        // 0x07 with word change and valid pulse mid-frame
        base = a_done;
        send_a(8'h07);
        repeat (30) @(negedge sysclk);
        word_a = 8'hFF; valid_a = 1'b1;
        repeat (4) @(negedge sysclk);
        check("x07_ready_held", ready_a, 0);
        valid_a = 1'b0;
        wait_idle_a();
        repeat (150) @(negedge sysclk);
        check("x07_frame", a_last, 11'b1_0_00000111_0);
        check("x07_one_frame", a_done - base, 1);
        expect_rx_a("x07_word", 8'h07);

        // Reset in the low half of bit index 4
        send_a(8'h00);
        repeat (37) @(negedge sysclk);
        check("pre_rst_clk", clk_a, 0);
        check("pre_rst_bits", a_n, 5);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_clk", clk_a, 1);
        check("mid_rst_dat", dat_a, 1);
        check("mid_rst_ready", ready_a, 1);
        check("mid_rst_busy", busy_a, 0);
        @(negedge sysclk);
        rst_n = 1'b1;
        a_rxq.delete();
        base = a_done;
        send_a(8'h3C);
        wait_idle_a();
        check("x3c_frame", a_last, 11'b1_1_00111100_0);
        check("x3c_one_frame", a_done - base, 1);
        expect_rx_a("x3c_word", 8'h3C);

        // Loopback 0x00..0xFF with valid held high on both instances
        a_rxq.delete(); b_rxq.delete();
        base = a_done; base_b = b_done; gbase = a_gaps; gbase_b = b_gaps;
        fork
            loop_a(to_a);
            loop_b(to_b);
        join
        wait_idle_a();
        wait_idle_b();
        check("lb_a_timeouts", to_a, 0);
        check("lb_b_timeouts", to_b, 0);
        check("lb_a_done", a_done - base, 256);
        check("lb_b_done", b_done - base_b, 256);
        check("lb_a_nrx", a_rxq.size(), 256);
        check("lb_b_nrx", b_rxq.size(), 256);
        for (int i = 0; i < a_rxq.size() && i < 256; i++) check("lb_a_word", a_rxq[i], i);
        for (int i = 0; i < b_rxq.size() && i < 256; i++) check("lb_b_word", b_rxq[i], i);
        check("lb_a_gaps", a_gaps - gbase, 256);
        check("lb_b_gaps", b_gaps - gbase_b, 256);
        check("a_gap_len_bad", a_gap_bad, 0);
        check("b_gap_len_bad", b_gap_bad, 0);
        check("a_format_bad", a_fmt_bad, 0);
        check("b_format_bad", b_fmt_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
